regfile_wb_arbiter: RTL



---
 rtl/regfile_wb_arbiter.sv | 86 ++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between integer writeback and FP results.
// Ports: clk/reset; int_valid/int_rd/int_wd integer writeback; fpu_issue/fpu_issue_rd mark busy;
// fpu_valid/fpu_rd/fpu_wd/fpu_ready FP result handshake; dec_rs1/dec_rs2/dec_rd -> hazard_stall;
// pipe_freeze holds the pipeline to drain a starved FIFO; we3/a3/wd3 drive the register file.
module regfile_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_valid,
  input  logic [4:0]  int_rd,
  input  logic [31:0] int_wd,
  input  logic        fpu_issue,
  input  logic [4:0]  fpu_issue_rd,
  input  logic        fpu_valid,
  input  logic [4:0]  fpu_rd,
  input  logic [31:0] fpu_wd,
  output logic        fpu_ready,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic [4:0]  dec_rd,
  output logic        hazard_stall,
  output logic        pipe_freeze,
  output logic        we3,
  output logic [4:0]  a3,
  output logic [31:0] wd3
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;
  ent_t          mem_q [DEPTH];
  logic [AW-1:0] rp_q, wp_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [SW-1:0] st_q, st_d;
  logic [31:0]   busy_q, busy_d;
  logic          empty, full, g_fifo, g_int, g_byp, push;
  logic [4:0]    w_rd;
  logic [31:0]   w_wd;
  ent_t          head;
  always_comb begin
    empty        = cnt_q == '0;
    full         = cnt_q == (AW+1)'(DEPTH);
    head         = mem_q[rp_q];
    pipe_freeze  = !reset & !empty & (st_q == SW'(STARVE_LIMIT));
    g_fifo       = !reset & !empty & (pipe_freeze | !int_valid);
    g_int        = !reset & int_valid & !pipe_freeze;
    // bypass only when nothing older is queued, so FIFO order is never overtaken
    g_byp        = !reset & fpu_valid & !int_valid & empty;
    fpu_ready    = !reset & (!full | g_fifo);
    push         = fpu_valid & fpu_ready & !g_byp;
    w_rd         = g_fifo ? head.rd : g_int ? int_rd : g_byp ? fpu_rd : '0;
    w_wd         = g_fifo ? head.wd : g_int ? int_wd : g_byp ? fpu_wd : '0;
    we3          = w_rd != '0;
    a3           = w_rd;
    wd3          = w_wd;
    // clear before set so an issue to the register being retired stays busy
    busy_d       = (busy_q & ~((g_fifo | g_byp) ? 32'd1 << w_rd : 32'd0))
                 | (fpu_issue ? 32'd1 << fpu_issue_rd : 32'd0);
    busy_d[0]    = 1'b0;
    hazard_stall = !reset & ((dec_rs1 != '0 & busy_q[dec_rs1]) |
                             (dec_rs2 != '0 & busy_q[dec_rs2]) |
                             (dec_rd  != '0 & busy_q[dec_rd]));
    st_d         = (empty | g_fifo) ? '0 : (g_int & st_q != SW'(STARVE_LIMIT)) ? st_q + 1'b1 : st_q;
    cnt_d        = cnt_q + (AW+1)'(push) - (AW+1)'(g_fifo);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rp_q   <= '0;
      wp_q   <= '0;
      cnt_q  <= '0;
      st_q   <= '0;
      busy_q <= '0;
    end else begin
      rp_q   <= rp_q + AW'(g_fifo);
      wp_q   <= wp_q + AW'(push);
      cnt_q  <= cnt_d;
      st_q   <= st_d;
      busy_q <= busy_d;
      if (push) mem_q[wp_q] <= '{rd: fpu_rd, wd: fpu_wd};
    end
  end
endmodule
